// File: rtl/dram_tg_pkg.sv
// ---------------------------------------------------------------------------
// dram_tg_pkg
// Shared types and helpers for the DRAM traffic generator:
//   state_t    - top-level sequencer states
//   mode_t     - data pattern selector
//   CMD_*      - MIG native UI command encodings
//   lfsr_step  - one step of the x^32+x^22+x^2+x+1 Fibonacci LFSR
//   lfsr_seed  - seed sanitiser (an all-zero LFSR would lock up)
// ---------------------------------------------------------------------------
package dram_tg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_CAL = 3'd1,
    ST_WRITE    = 3'd2,
    ST_READ     = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    MODE_ADDR  = 2'd0,
    MODE_LFSR  = 2'd1,
    MODE_WALK  = 2'd2,
    MODE_FIXED = 2'd3
  } mode_t;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  // Feedback taps for x^32 + x^22 + x^2 + x + 1 -> state bits 31, 21, 1, 0.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] LFSR_INIT = 32'h0000_0001;

  // Shift left, new LSB is the XOR of the tapped bits.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic [31:0] lfsr_seed(input logic [31:0] s);
    return (s == 32'h0) ? LFSR_INIT : s;
  endfunction

endpackage

// File: rtl/dram_tg_pattern.sv
// ---------------------------------------------------------------------------
// dram_tg_pattern
// Per-beat data pattern generator. One instance produces the write stream,
// a second identical instance regenerates the expected read stream.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   load        - restart the LFSR from seed (phase start)
//   advance     - step the LFSR (one beat consumed)
//   mode        - pattern select
//   seed        - LFSR seed / fixed word
//   addr        - address of the current beat (address pattern)
//   idx         - beat index within the phase (walking-one pattern)
//   data        - pattern word for the current beat
// ---------------------------------------------------------------------------
module dram_tg_pattern
  import dram_tg_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 29,
  parameter int LEN_W  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  mode_t             mode,
  input  logic [31:0]       seed,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  idx,
  output logic [DATA_W-1:0] data
);

  localparam int WORDS = DATA_W / 32;

  logic [31:0]       lfsr_reg;
  logic [31:0]       addr_word;
  logic [LEN_W-1:0]  walk_pos;
  logic [DATA_W-1:0] walk_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_reg <= LFSR_INIT;
    end else if (load) begin
      lfsr_reg <= lfsr_seed(seed);
    end else if (advance) begin
      lfsr_reg <= lfsr_step(lfsr_reg);
    end
  end

  assign addr_word = 32'(addr);
  assign walk_pos  = idx % LEN_W'(DATA_W);
  assign walk_data = {{(DATA_W-1){1'b0}}, 1'b1} << walk_pos;

  // Every 32-bit lane picks its word independently; only the walking-one
  // pattern differs between lanes.
  for (genvar gi = 0; gi < WORDS; gi++) begin : g_lane
    always_comb begin
      data[gi*32 +: 32] = seed;
      unique case (mode)
        MODE_ADDR:  data[gi*32 +: 32] = addr_word;
        MODE_LFSR:  data[gi*32 +: 32] = lfsr_reg;
        MODE_WALK:  data[gi*32 +: 32] = walk_data[gi*32 +: 32];
        MODE_FIXED: data[gi*32 +: 32] = seed;
        default:    data[gi*32 +: 32] = seed;
      endcase
    end
  end

endmodule

// File: rtl/dram_traffic_gen.sv
// ---------------------------------------------------------------------------
// dram_traffic_gen
// Writes a data pattern over an address region through the MIG native UI,
// reads it back and checks it in order; optionally loops until stopped.
// Ports:
//   clk, rst_n            - UI clock, synchronous active-low reset
//   calib_done            - MIG calibration complete; gates all commands
//   start, stop           - run control pulses (stop has priority)
//   continuous            - loop WRITE->READ until stop (sampled at start)
//   mode, seed, base_addr, num_beats - run configuration (sampled at start)
//   err_inject            - corrupt bit 0 of the next written beat
//   app_*                 - MIG native UI command / write / read channels
//   busy, done            - run status
//   tg_compare_error, err_count, first_err_addr, pass_count - checker status
// ---------------------------------------------------------------------------
module dram_traffic_gen
  import dram_tg_pkg::*;
#(
  parameter int DATA_W   = 128,
  parameter int ADDR_W   = 29,
  parameter int ADDR_INC = 8,
  parameter int LEN_W    = 24,
  parameter int MAX_OUT  = 32,
  parameter int ERRCNT_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                calib_done,
  input  logic                start,
  input  logic                stop,
  input  logic                continuous,
  input  logic [1:0]          mode,
  input  logic [31:0]         seed,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [LEN_W-1:0]    num_beats,
  input  logic                err_inject,
  output logic [ADDR_W-1:0]   app_addr,
  output logic [2:0]          app_cmd,
  output logic                app_en,
  input  logic                app_rdy,
  output logic [DATA_W-1:0]   app_wdf_data,
  output logic                app_wdf_wren,
  output logic                app_wdf_end,
  input  logic                app_wdf_rdy,
  input  logic [DATA_W-1:0]   app_rd_data,
  input  logic                app_rd_data_valid,
  output logic                busy,
  output logic                done,
  output logic                tg_compare_error,
  output logic [ERRCNT_W-1:0] err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [15:0]         pass_count
);

  localparam int OUT_W = $clog2(MAX_OUT) + 1;
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(ADDR_INC);

  state_t              state_reg;
  mode_t               mode_reg;
  logic [31:0]         seed_reg;
  logic [ADDR_W-1:0]   base_reg;
  logic [LEN_W-1:0]    len_reg;
  logic                cont_reg;
  logic                drain_reg;
  logic [LEN_W-1:0]    cmd_idx_reg;
  logic [ADDR_W-1:0]   cmd_addr_reg;
  logic [LEN_W-1:0]    exp_idx_reg;
  logic [ADDR_W-1:0]   exp_addr_reg;
  logic [OUT_W-1:0]    out_reg;
  logic                inject_pend_reg;
  logic                err_reg;
  logic [ERRCNT_W-1:0] err_count_reg;
  logic [ADDR_W-1:0]   first_err_reg;
  logic [15:0]         pass_reg;

  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] exp_data;
  logic              start_ok;
  logic              wr_fire;
  logic              last_wr;
  logic              rd_en;
  logic              rd_accept;
  logic              rd_ret;
  logic              rd_mismatch;
  logic              read_exit;
  logic              go_write_cal;
  logic              loop_back;
  logic              wr_load;
  logic              inject_now;

  // ---- handshake / control decode ----
  assign start_ok = start && !stop && (state_reg == ST_IDLE || state_reg == ST_DONE);

  // A write beat is only offered when both the command and data FIFOs can
  // take it, so command and data always move together.
  assign wr_fire = (state_reg == ST_WRITE) && calib_done && !stop && app_rdy && app_wdf_rdy;
  assign last_wr = wr_fire && (cmd_idx_reg == len_reg - LEN_W'(1));

  assign rd_en = (state_reg == ST_READ) && calib_done && !stop && !drain_reg &&
                 (cmd_idx_reg != len_reg) && (out_reg < OUT_W'(MAX_OUT));
  assign rd_accept = rd_en && app_rdy;

  // Returns with nothing outstanding cannot belong to this run; drop them.
  assign rd_ret      = (state_reg == ST_READ) && app_rd_data_valid && (out_reg != '0);
  assign rd_mismatch = rd_ret && (app_rd_data != exp_data);

  assign read_exit = (state_reg == ST_READ) && (out_reg == '0) &&
                     (drain_reg || stop || (cmd_idx_reg == len_reg));

  assign go_write_cal = (state_reg == ST_WAIT_CAL) && !stop && calib_done;
  assign loop_back    = read_exit && cont_reg && !stop && !drain_reg;
  assign wr_load      = go_write_cal || loop_back;

  assign inject_now = inject_pend_reg || err_inject;

  // ---- pattern generators ----
  dram_tg_pattern #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_wr_pat (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (wr_load),
    .advance (wr_fire),
    .mode    (mode_reg),
    .seed    (seed_reg),
    .addr    (cmd_addr_reg),
    .idx     (cmd_idx_reg),
    .data    (wr_data)
  );

  dram_tg_pattern #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_exp_pat (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (last_wr),
    .advance (rd_ret),
    .mode    (mode_reg),
    .seed    (seed_reg),
    .addr    (exp_addr_reg),
    .idx     (exp_idx_reg),
    .data    (exp_data)
  );

  // ---- sequencer, counters and checker ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      mode_reg        <= MODE_ADDR;
      seed_reg        <= '0;
      base_reg        <= '0;
      len_reg         <= '0;
      cont_reg        <= 1'b0;
      drain_reg       <= 1'b0;
      cmd_idx_reg     <= '0;
      cmd_addr_reg    <= '0;
      exp_idx_reg     <= '0;
      exp_addr_reg    <= '0;
      out_reg         <= '0;
      inject_pend_reg <= 1'b0;
      err_reg         <= 1'b0;
      err_count_reg   <= '0;
      first_err_reg   <= '0;
      pass_reg        <= '0;
    end else begin
      // The pending injection is consumed by whichever beat transfers next.
      if (wr_fire) begin
        inject_pend_reg <= 1'b0;
      end else if (err_inject) begin
        inject_pend_reg <= 1'b1;
      end

      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            state_reg     <= ST_WAIT_CAL;
            mode_reg      <= mode_t'(mode);
            seed_reg      <= seed;
            base_reg      <= base_addr;
            len_reg       <= (num_beats == '0) ? LEN_W'(1) : num_beats;
            cont_reg      <= continuous;
            drain_reg     <= 1'b0;
            err_reg       <= 1'b0;
            err_count_reg <= '0;
            first_err_reg <= '0;
            pass_reg      <= '0;
          end
        end

        ST_WAIT_CAL: begin
          if (stop) begin
            state_reg <= ST_DONE;
            cont_reg  <= 1'b0;
          end else if (calib_done) begin
            state_reg    <= ST_WRITE;
            cmd_idx_reg  <= '0;
            cmd_addr_reg <= base_reg;
          end
        end

        ST_WRITE: begin
          if (stop) begin
            state_reg <= ST_DONE;
            cont_reg  <= 1'b0;
          end else if (last_wr) begin
            state_reg    <= ST_READ;
            cmd_idx_reg  <= '0;
            cmd_addr_reg <= base_reg;
            exp_idx_reg  <= '0;
            exp_addr_reg <= base_reg;
            out_reg      <= '0;
          end else if (wr_fire) begin
            cmd_idx_reg  <= cmd_idx_reg + LEN_W'(1);
            cmd_addr_reg <= cmd_addr_reg + ADDR_STEP;
          end
        end

        ST_READ: begin
          if (stop) begin
            drain_reg <= 1'b1;
            cont_reg  <= 1'b0;
          end

          if (rd_accept) begin
            cmd_idx_reg  <= cmd_idx_reg + LEN_W'(1);
            cmd_addr_reg <= cmd_addr_reg + ADDR_STEP;
          end

          if (rd_accept && !rd_ret) begin
            out_reg <= out_reg + OUT_W'(1);
          end else if (!rd_accept && rd_ret) begin
            out_reg <= out_reg - OUT_W'(1);
          end

          if (rd_ret) begin
            exp_idx_reg  <= exp_idx_reg + LEN_W'(1);
            exp_addr_reg <= exp_addr_reg + ADDR_STEP;
            if (rd_mismatch) begin
              err_reg <= 1'b1;
              if (err_count_reg != {ERRCNT_W{1'b1}}) begin
                err_count_reg <= err_count_reg + ERRCNT_W'(1);
              end
              if (err_count_reg == '0) begin
                first_err_reg <= exp_addr_reg;
              end
            end
          end

          // read_exit implies nothing outstanding and no accept this cycle,
          // so the counter updates above cannot collide with these.
          if (read_exit) begin
            pass_reg <= pass_reg + 16'd1;
            if (loop_back) begin
              state_reg    <= ST_WRITE;
              cmd_idx_reg  <= '0;
              cmd_addr_reg <= base_reg;
            end else begin
              state_reg <= ST_DONE;
              drain_reg <= 1'b0;
            end
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // ---- outputs ----
  assign app_addr     = cmd_addr_reg;
  assign app_cmd      = (state_reg == ST_READ) ? CMD_READ : CMD_WRITE;
  assign app_en       = wr_fire || rd_en;
  assign app_wdf_wren = wr_fire;
  assign app_wdf_end  = wr_fire;
  assign app_wdf_data = (state_reg == ST_WRITE) ?
                        (wr_data ^ {{(DATA_W-1){1'b0}}, inject_now}) : '0;

  assign busy             = !(state_reg == ST_IDLE || state_reg == ST_DONE);
  assign done             = (state_reg == ST_DONE);
  assign tg_compare_error = err_reg;
  assign err_count        = err_count_reg;
  assign first_err_addr   = first_err_reg;
  assign pass_count       = pass_reg;

endmodule
